// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states, the
// zero-register index and the bundled enable/flush control word.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } pipe_state_e;

    localparam int XZR_IDX = 31;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID. The zero register never carries a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rn_i,
    input  logic [REG_W-1:0] id_rm_i,
    input  logic             id_uses_rn_i,
    input  logic             id_uses_rm_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_mem_read_i,
    output logic             load_use_o
);

    logic rn_match;
    logic rm_match;

    assign rn_match   = id_uses_rn_i && (id_rn_i == ex_rd_i);
    assign rm_match   = id_uses_rm_i && (id_rm_i == ex_rd_i);
    assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_W'(XZR_IDX)) && (rn_match || rm_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencing: memory-wait freeze with timeout fault, branch
// flush and load-use stall. Optional performance counters: PIPE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int REG_W       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_rn,
    input  logic [REG_W-1:0]  id_rm,
    input  logic              id_uses_rn,
    input  logic              id_uses_rm,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              mem_fault,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_cycles,
    output pipe_state_e       state_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    pipe_state_e      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    pipe_ctrl_t       ctrl;
    logic             load_use;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .id_rn_i       (id_rn),
        .id_rm_i       (id_rm),
        .id_uses_rn_i  (id_uses_rn),
        .id_uses_rm_i  (id_uses_rm),
        .ex_rd_i       (ex_rd),
        .ex_mem_read_i (ex_mem_read),
        .load_use_o    (load_use)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctrl       = '0;
        case (state_q)
            ST_FAULT: begin
                ctrl = '0;
            end
            default: begin
                if (mem_req && !mem_ready) begin
                    // Everything freezes, including a taken branch held in EX.
                    ctrl = '0;
                    if (wait_cnt_q < TIMEOUT_VAL) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    state_d = (wait_cnt_d == TIMEOUT_VAL) ? ST_FAULT : ST_MEM_WAIT;
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    if (ex_branch_taken) begin
                        ctrl = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                                 memwb_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
                    end else if (load_use) begin
                        ctrl = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1,
                                 memwb_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b1};
                    end else begin
                        ctrl = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                                 memwb_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
                    end
                end
            end
        endcase
        if (reset) begin
            ctrl = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
                     memwb_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign idex_en    = ctrl.idex_en;
    assign exmem_en   = ctrl.exmem_en;
    assign memwb_en   = ctrl.memwb_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;
    assign mem_fault  = (state_q == ST_FAULT) && !reset;
    assign state_o    = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        stall_evt;
    logic        flush_evt;

    // Outside reset, flushes can only come from the branch or load-use rules.
    assign stall_evt = !reset && !ctrl.pc_en;
    assign flush_evt = !reset && (ctrl.ifid_flush || ctrl.idex_flush);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_cycles = 32'd0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the five-stage CPU pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards, taken-branch redirects and data-memory wait states. From these it drives per-register enable and flush (bubble-insert) controls plus the PC write enable. It sits beside the hazard/forwarding logic in the top-level CPU and is the only source of stall and flush for the pipeline registers.

## Interface
Parameters:
- MEM_TIMEOUT, 16, maximum consecutive MEM wait cycles before fault (≥1)
- REG_W, 5, register-index width

Ports:
- clk  input  1  pipeline clock; all state on rising edge
- reset  input  1  synchronous, active-high
- id_rn, id_rm  input  REG_W  source registers of the instruction in ID
- id_uses_rn, id_uses_rm  input  1  source actually read
- ex_rd  input  REG_W  destination of the instruction in EX
- ex_mem_read  input  1  EX instruction is a load
- ex_branch_taken  input  1  EX resolved a taken branch
- mem_req  input  1  MEM stage has an outstanding data-memory access
- mem_ready  input  1  data memory completes the access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1  register load enables
- ifid_flush, idex_flush  output  1  load a bubble (all-zero NOP) instead of d
- mem_fault  output  1  sticky timeout indicator
- stall_cycles, flush_cycles  output  32  performance counters (macro-gated)

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Reset → RUN, timeout counter 0, mem_fault 0.
- Control decode is combinational from state and inputs (Mealy) and applies in the same cycle. Priority is highest first:
  1. FAULT: all enables 0, flushes 0, mem_fault 1.
  2. Memory wait (mem_req && !mem_ready, in RUN or MEM_WAIT): all five enables 0, flushes 0. Next state is MEM_WAIT. The counter increments; when it reaches MEM_TIMEOUT, next state is FAULT.
  3. Branch (ex_branch_taken): all enables 1, ifid_flush=1, idex_flush=1.
  4. Load-use (ex_mem_read && ex_rd!=31 && ((id_uses_rn && id_rn==ex_rd) || (id_uses_rm && id_rm==ex_rd))): pc_en=0, ifid_en=0, idex_flush=1, the rest 1.
  5. Otherwise: all enables 1, flushes 0.
- Handshake: in MEM_WAIT, a cycle with mem_ready=1 (or mem_req=0) returns the state to RUN and clears the counter. That same cycle is decoded normally by rules 3–5.
- Register 31 (XZR) never creates a load-use hazard.
- Branch plus load-use in the same cycle: branch wins, because the dependent instruction is flushed anyway.
- Branch during a memory wait: frozen. The branch is still held in EX and is applied on the release cycle.
- Reset mid-wait or in FAULT returns the FSM to RUN immediately.

## Timing
- While reset is high, outputs are forced to: all enables 0, ifid_flush=1, idex_flush=1, mem_fault=0. The first cycle after reset deasserts decodes normally.
- Stall/flush latency is 0 cycles (combinational).
- A load-use stall lasts exactly 1 cycle per hazard. A branch flush lasts 1 cycle.
- Timeout: with mem_req=1 and mem_ready=0 held, FAULT is entered on the edge ending wait cycle MEM_TIMEOUT. mem_fault rises the next cycle.
- Counter width is $clog2(MEM_TIMEOUT+1). The counter never wraps.

## Configuration
- PIPE_HAZARD_PERF_EN defined:
  - stall_cycles increments each cycle in which pc_en=0, outside reset.
  - flush_cycles increments each cycle in which ifid_flush or idex_flush is 1 due to rule 3 or 4.
  - Both counters saturate at 2^32−1 and clear on reset.
- Not defined: both counter outputs are tied to 0 and no counter flops are synthesized.

## Structure
- Shared package pipe_ctrl_pkg: FSM state enum (RUN, MEM_WAIT, FAULT), constant XZR_IDX=31, and a pipe_ctrl_t struct bundling the enable/flush bits.
- One sub-module, hazard_detect: purely combinational load-use compare, instantiated once.
- Pipeline registers stay separate modules fed by these controls.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=3, id_rn=3, id_uses_rn=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1. Same stimulus with ex_rd=31 → no stall.
- Branch + hazard same cycle: ex_branch_taken=1 with a load-use match → ifid_flush=1, idex_flush=1, pc_en=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → enables 0 for 3 cycles, then 1, state RUN, no fault.
- Timeout: mem_req=1, mem_ready held 0 for 16 cycles → mem_fault=1 from cycle 17 and sticky. Reset → mem_fault=0, state RUN.
- Reset mid-wait: reset asserted in wait cycle 2 → flushes 1 and enables 0 during reset. Counter 0 afterwards.
- PIPE_HAZARD_PERF_EN: 5 load-use stalls plus 2 branches → stall_cycles=5, flush_cycles=7. Without the macro → both counters read 0.
